// File: rtl/exu_cdb_arbiter_if.sv
// Producer-to-CDB bundle for exu_cdb_arbiter.
// Master drives results and consumes the broadcast; slave is the arbiter.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif

interface exu_cdb_arbiter_if;
  logic                    alu_valid;
  logic [`ROB_ID_WIDTH:0]  alu_lab;
  logic [`VAL_WIDTH-1:0]   alu_val;
  logic                    alu_ready;
  logic                    mul_valid;
  logic [`ROB_ID_WIDTH:0]  mul_lab;
  logic [`VAL_WIDTH-1:0]   mul_val;
  logic                    mul_ready;
  logic                    cdb_en;
  logic [`ROB_ID_WIDTH:0]  cdb_lab;
  logic [`VAL_WIDTH-1:0]   cdb_val;

  modport master (
    output alu_valid, alu_lab, alu_val,
    output mul_valid, mul_lab, mul_val,
    input  alu_ready, mul_ready,
    input  cdb_en, cdb_lab, cdb_val
  );

  modport slave (
    input  alu_valid, alu_lab, alu_val,
    input  mul_valid, mul_lab, mul_val,
    output alu_ready, mul_ready,
    output cdb_en, cdb_lab, cdb_val
  );
endinterface

// File: rtl/exu_cdb_arbiter.sv
// ALU + MUL/DIV result merger: per-source FIFOs, round-robin onto the CDB.
// Define EXU_CDB_BYPASS_EN to let an empty-FIFO winner skip its FIFO.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif

module exu_cdb_arbiter #(
  parameter int DEPTH_LOG = 2
) (
  input logic              clk,
  input logic              rst_in,
  input logic              rdy_in,
  input logic              flush,
  exu_cdb_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int LW = `ROB_ID_WIDTH + 1;
  localparam int VW = `VAL_WIDTH;
  localparam int CW = DEPTH_LOG + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic { SRC_ALU, SRC_MUL } src_e;

  logic [LW-1:0] alu_lab_m [DEPTH];
  logic [VW-1:0] alu_val_m [DEPTH];
  logic [LW-1:0] mul_lab_m [DEPTH];
  logic [VW-1:0] mul_val_m [DEPTH];

  logic [CW-1:0]        alu_cnt, mul_cnt;
  logic [DEPTH_LOG-1:0] alu_wp, alu_rp;
  logic [DEPTH_LOG-1:0] mul_wp, mul_rp;
  src_e                 last_grant;

  logic          cdb_en_q;
  logic [LW-1:0] cdb_lab_q;
  logic [VW-1:0] cdb_val_q;

  logic alu_rdy, mul_rdy;
  logic alu_byp, mul_byp;
  logic alu_ne, mul_ne, tie;
  logic gnt_alu, gnt_mul;
  logic alu_enq, mul_enq;
  logic alu_deq, mul_deq;
  logic clr;

  always_comb begin
    alu_rdy = rdy_in && (alu_cnt != FULL);
    mul_rdy = rdy_in && (mul_cnt != FULL);
`ifdef EXU_CDB_BYPASS_EN
    alu_byp = (alu_cnt == '0) && bus.alu_valid;
    mul_byp = (mul_cnt == '0) && bus.mul_valid;
`else
    alu_byp = 1'b0;
    mul_byp = 1'b0;
`endif
    alu_ne  = (alu_cnt != '0) || alu_byp;
    mul_ne  = (mul_cnt != '0) || mul_byp;
    tie     = alu_ne && mul_ne;
    gnt_alu = alu_ne && (!mul_ne || last_grant == SRC_MUL);
    gnt_mul = mul_ne && !gnt_alu;
    // a bypassed winner goes straight to the CDB, never into its FIFO
    alu_enq = bus.alu_valid && alu_rdy && !(gnt_alu && alu_byp);
    mul_enq = bus.mul_valid && mul_rdy && !(gnt_mul && mul_byp);
    alu_deq = gnt_alu && !alu_byp;
    mul_deq = gnt_mul && !mul_byp;
    clr     = rst_in || flush;
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.mul_ready = mul_rdy;
  assign bus.cdb_en    = cdb_en_q;
  assign bus.cdb_lab   = cdb_lab_q;
  assign bus.cdb_val   = cdb_val_q;

  always_ff @(posedge clk) begin
    if (!clr && rdy_in) begin
      if (alu_enq) begin
        alu_lab_m[alu_wp] <= bus.alu_lab;
        alu_val_m[alu_wp] <= bus.alu_val;
      end
      if (mul_enq) begin
        mul_lab_m[mul_wp] <= bus.mul_lab;
        mul_val_m[mul_wp] <= bus.mul_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      alu_cnt    <= '0;
      mul_cnt    <= '0;
      alu_wp     <= '0;
      alu_rp     <= '0;
      mul_wp     <= '0;
      mul_rp     <= '0;
      last_grant <= SRC_MUL;
      cdb_en_q   <= 1'b0;
      cdb_lab_q  <= '0;
      cdb_val_q  <= '0;
    end else if (rdy_in) begin
      if (alu_enq) alu_wp <= alu_wp + 1'b1;
      if (mul_enq) mul_wp <= mul_wp + 1'b1;
      if (alu_deq) alu_rp <= alu_rp + 1'b1;
      if (mul_deq) mul_rp <= mul_rp + 1'b1;
      alu_cnt <= alu_cnt + CW'(alu_enq) - CW'(alu_deq);
      mul_cnt <= mul_cnt + CW'(mul_enq) - CW'(mul_deq);
      if (tie) last_grant <= gnt_alu ? SRC_ALU : SRC_MUL;
      unique case (1'b1)
        gnt_alu: begin
          cdb_en_q  <= 1'b1;
          cdb_lab_q <= alu_byp ? bus.alu_lab : alu_lab_m[alu_rp];
          cdb_val_q <= alu_byp ? bus.alu_val : alu_val_m[alu_rp];
        end
        gnt_mul: begin
          cdb_en_q  <= 1'b1;
          cdb_lab_q <= mul_byp ? bus.mul_lab : mul_lab_m[mul_rp];
          cdb_val_q <= mul_byp ? bus.mul_val : mul_val_m[mul_rp];
        end
        default: cdb_en_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_cdb_arbiter.sv
// Bench for exu_cdb_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based model.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif

module tb_exu_cdb_arbiter;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;
  localparam int LW = `ROB_ID_WIDTH + 1;
  localparam int VW = `VAL_WIDTH;

  typedef struct packed {
    logic [LW-1:0] lab;
    logic [VW-1:0] val;
  } ent_t;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush;

  exu_cdb_arbiter_if bus ();

  exu_cdb_arbiter #(.DEPTH_LOG(DL)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  ent_t          aq[$], mq[$];
  bit            last_mul;
  logic          e_en;
  logic [LW-1:0] e_lab;
  logic [VW-1:0] e_val;
  int            log_lab[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic av, input logic [LW-1:0] al,
                      input logic [VW-1:0] aval,
                      input logic mv, input logic [LW-1:0] ml,
                      input logic [VW-1:0] mval,
                      input logic rdy, input logic fl,
                      input logic rst);
    bit a_ok, m_ok, a_byp, m_byp, a_has, m_has;
    int win;
    ent_t e;
    rst_in = rst; flush = fl; rdy_in = rdy;
    bus.alu_valid = av; bus.alu_lab = al; bus.alu_val = aval;
    bus.mul_valid = mv; bus.mul_lab = ml; bus.mul_val = mval;
    #1;
    if (!rst) begin
      chk("alu_ready", 64'(bus.alu_ready),
          64'(rdy && aq.size() < DEPTH));
      chk("mul_ready", 64'(bus.mul_ready),
          64'(rdy && mq.size() < DEPTH));
    end
    if (rst || fl) begin
      aq.delete(); mq.delete();
      last_mul = 1'b1;
      e_en = 0; e_lab = '0; e_val = '0;
    end else if (rdy) begin
      a_ok = av && aq.size() < DEPTH;
      m_ok = mv && mq.size() < DEPTH;
      a_byp = 0; m_byp = 0;
`ifdef EXU_CDB_BYPASS_EN
      a_byp = av && aq.size() == 0;
      m_byp = mv && mq.size() == 0;
`endif
      a_has = aq.size() > 0 || a_byp;
      m_has = mq.size() > 0 || m_byp;
      win = 0;
      if (a_has && m_has) begin
        win = last_mul ? 1 : 2;
        last_mul = (win == 2);
      end else if (a_has) win = 1;
      else if (m_has) win = 2;
      e_en = (win != 0);
      if (win == 1) begin
        if (a_byp) begin
          e_lab = al; e_val = aval; a_ok = 0;
        end else begin
          e = aq.pop_front(); e_lab = e.lab; e_val = e.val;
        end
      end else if (win == 2) begin
        if (m_byp) begin
          e_lab = ml; e_val = mval; m_ok = 0;
        end else begin
          e = mq.pop_front(); e_lab = e.lab; e_val = e.val;
        end
      end
      if (a_ok) aq.push_back('{al, aval});
      if (m_ok) mq.push_back('{ml, mval});
    end
    @(posedge clk);
    #1;
    chk("cdb_en", 64'(bus.cdb_en), 64'(e_en));
    chk("cdb_lab", 64'(bus.cdb_lab), 64'(e_lab));
    chk("cdb_val", 64'(bus.cdb_val), 64'(e_val));
    if (bus.cdb_en === 1'b1) log_lab.push_back(int'(bus.cdb_lab));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, '0, '0, 0, '0, '0, 1, 0, 0);
  endtask

  initial begin
    int exp_seq[8];
    int ai, mi, na, nm;
    logic av, mv, rdy, fl;
    rst_in = 1; rdy_in = 1; flush = 0;
    bus.alu_valid = 0; bus.alu_lab = '0; bus.alu_val = '0;
    bus.mul_valid = 0; bus.mul_lab = '0; bus.mul_val = '0;
    @(negedge clk);

    // reset, then a single ALU result
    step(0, '0, '0, 0, '0, '0, 1, 0, 1);
    step(1, LW'(5), VW'(32'h1234), 0, '0, '0, 1, 0, 0);
    idle(3);

    // strict alternation under contention
    log_lab.delete();
    for (int i = 0; i < 4; i++)
      step(1, LW'(i + 1), VW'($urandom),
           1, LW'(i + 9), VW'($urandom), 1, 0, 0);
    idle(6);
    exp_seq = '{1, 9, 2, 10, 3, 11, 4, 12};
    chk("contention_len", 64'(log_lab.size()), 64'(8));
    for (int i = 0; i < 8 && i < log_lab.size(); i++)
      chk("contention_seq", 64'(log_lab[i]), 64'(exp_seq[i]));

    // both FIFOs filling: hold each valid until accepted
    log_lab.delete();
    ai = 0; mi = 0;
    for (int c = 0; c < 40 && (ai < 8 || mi < 8); c++) begin
      av = (ai < 8); mv = (mi < 8);
      na = (av && aq.size() < DEPTH) ? ai + 1 : ai;
      nm = (mv && mq.size() < DEPTH) ? mi + 1 : mi;
      step(av, LW'(ai + 1), VW'($urandom),
           mv, LW'(mi + 9), VW'($urandom), 1, 0, 0);
      ai = na; mi = nm;
    end
    idle(12);
    chk("full_total", 64'(log_lab.size()), 64'(16));
    na = 0; nm = 0;
    foreach (log_lab[i]) begin
      if (log_lab[i] <= 8) begin
        na++;
        chk("full_alu_order", 64'(log_lab[i]), 64'(na));
      end else begin
        nm++;
        chk("full_mul_order", 64'(log_lab[i]), 64'(nm + 8));
      end
    end

    // flush mid-stream, with an ALU result on the flush edge
    for (int i = 0; i < 5; i++)
      step(1, LW'(i + 1), VW'($urandom),
           1, LW'(i + 17), VW'($urandom), 1, 0, 0);
    step(1, LW'(30), VW'($urandom), 0, '0, '0, 1, 1, 0);
    idle(3);
    log_lab.delete();
    step(1, LW'(2), VW'($urandom), 1, LW'(3), VW'($urandom), 1, 0, 0);
    idle(4);
    chk("flush_first_alu", 64'(log_lab.size() > 0 ? log_lab[0] : -1),
        64'(2));

    // stall while broadcasting
    step(1, LW'(7), VW'($urandom), 0, '0, '0, 1, 0, 0);
    step(1, LW'(8), VW'($urandom), 1, LW'(6), VW'($urandom), 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, LW'(1), VW'($urandom), 1, LW'(1), VW'($urandom), 0, 0, 0);
    idle(6);

    // ALU-only wrap-around through the pointers
    log_lab.delete();
    for (int i = 0; i < 10; i++)
      step(1, LW'(i), VW'($urandom), 0, '0, '0, 1, 0, 0);
    idle(4);
    chk("wrap_len", 64'(log_lab.size()), 64'(10));
    for (int i = 0; i < 10 && i < log_lab.size(); i++)
      chk("wrap_seq", 64'(log_lab[i]), 64'(i));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      av  = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      step(av, LW'($urandom), VW'($urandom),
           mv, LW'($urandom), VW'($urandom), rdy, fl, 0);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
